// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: word field layout,
// FSM state encodings and the halt opcode used when IFETCH_HALT_EN is defined.
package instruction_fetch_pkg;

  localparam int WORD_W   = 9;
  localparam int FMT_BIT  = 8;
  localparam int OPC_MSB  = 7;
  localparam int OPC_LSB  = 4;
  localparam int SIGN_BIT = 3;
  localparam int OPR_MSB  = 2;
  localparam int OPR_LSB  = 0;
  localparam int IMM_W    = 8;

  localparam logic [3:0] OPC_HALT = 4'hF;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_IMM   = 2'd1,
    S_HALT  = 2'd2
  } ifetch_state_t;

  typedef struct packed {
    logic       fmt;
    logic [3:0] opcode;
    logic       sign;
    logic [2:0] operand;
  } ifetch_fields_t;

  function automatic ifetch_fields_t decode_word(input logic [WORD_W-1:0] w);
    ifetch_fields_t f;
    f.fmt     = w[FMT_BIT];
    f.opcode  = w[OPC_MSB:OPC_LSB];
    f.sign    = w[SIGN_BIT];
    f.operand = w[OPR_MSB:OPR_LSB];
    return f;
  endfunction

endpackage

// File: rtl/instruction_fetch_pc.sv
// Program counter register: reset value, load (redirect), increment, otherwise hold.
// Increment wraps modulo 2^ADDR_W.
module ifetch_pc #(
  parameter int          ADDR_W   = 10,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_value,
  input  logic              inc,
  output logic [ADDR_W-1:0] pc
);

  always_ff @(posedge clock) begin
    if (reset) begin
      pc <= ADDR_W'(RESET_PC);
    end else if (load) begin
      pc <= load_value;
    end else if (inc) begin
      pc <= pc + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, assembles one- and two-word instructions and drives
// the IF/ID field bundle plus a flush pulse on taken branches. Optional S_HALT via IFETCH_HALT_EN.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int          ADDR_W   = 10,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [8:0]        imem_data,
  output logic              out_format,
  output logic [3:0]        out_opcode,
  output logic              out_sign,
  output logic [2:0]        out_operand,
  output logic [7:0]        out_immediate,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_pc,
  output logic              flush
);

  // Handshake: the bundle is a write-only valid interface; out_valid marks a new
  // instruction, and it and all fields hold unchanged while stall is high.

  ifetch_state_t     state;
  ifetch_state_t     state_next;
  logic [ADDR_W-1:0] pc;
  ifetch_fields_t    word;
  ifetch_fields_t    first_q;
  logic [ADDR_W-1:0] first_pc_q;

  logic pc_load;
  logic pc_inc;
  logic emit_short;
  logic emit_long;
  logic latch_first;
  logic drop_valid;

  assign imem_addr = pc;
  assign word      = decode_word(imem_data);

  ifetch_pc #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clock      (clock),
    .reset      (reset),
    .load       (pc_load),
    .load_value (branch_target),
    .inc        (pc_inc),
    .pc         (pc)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_FETCH;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    pc_load     = 1'b0;
    pc_inc      = 1'b0;
    emit_short  = 1'b0;
    emit_long   = 1'b0;
    latch_first = 1'b0;
    drop_valid  = 1'b0;
    if (branch_taken) begin
      state_next = S_FETCH;
      pc_load    = 1'b1;
      drop_valid = 1'b1;
    end else if (!stall) begin
      case (state)
        S_FETCH: begin
          pc_inc = 1'b1;
          if (word.fmt) begin
            latch_first = 1'b1;
            drop_valid  = 1'b1;
            state_next  = S_IMM;
          end else begin
            emit_short = 1'b1;
`ifdef IFETCH_HALT_EN
            if (word.opcode == OPC_HALT) begin
              state_next = S_HALT;
            end
`endif
          end
        end
        S_IMM: begin
          pc_inc     = 1'b1;
          emit_long  = 1'b1;
          state_next = S_FETCH;
        end
`ifdef IFETCH_HALT_EN
        S_HALT: begin
          drop_valid = 1'b1;
        end
`endif
        default: begin
          state_next = S_FETCH;
        end
      endcase
    end
  end

  // First word of an immediate-format instruction and its address.
  always_ff @(posedge clock) begin
    if (reset) begin
      first_q    <= '0;
      first_pc_q <= '0;
    end else if (latch_first) begin
      first_q    <= word;
      first_pc_q <= pc;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_format    <= 1'b0;
      out_opcode    <= '0;
      out_sign      <= 1'b0;
      out_operand   <= '0;
      out_immediate <= '0;
      out_valid     <= 1'b0;
      out_pc        <= '0;
      flush         <= 1'b0;
    end else begin
      flush <= branch_taken;
      if (emit_short) begin
        out_format    <= word.fmt;
        out_opcode    <= word.opcode;
        out_sign      <= word.sign;
        out_operand   <= word.operand;
        out_immediate <= '0;
        out_pc        <= pc;
        out_valid     <= 1'b1;
      end else if (emit_long) begin
        out_format    <= first_q.fmt;
        out_opcode    <= first_q.opcode;
        out_sign      <= first_q.sign;
        out_operand   <= first_q.operand;
        out_immediate <= imem_data[IMM_W-1:0];
        out_pc        <= first_pc_q;
        out_valid     <= 1'b1;
      end else if (drop_valid) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Fetch stage that produces the decoded field bundle consumed by the IF/ID pipeline register: format, opcode, sign, operand, immediate.
- Owns the program counter and drives instruction-memory addresses.
- Assembles two-word (immediate-format) instructions and generates the flush pulse for the ID register on taken branches.
- Sits between instruction memory and the IF/ID register; the writer side of that interface.

Parameters:
- ADDR_W, 10, PC / instruction-memory address width
- RESET_PC, 0, PC value loaded on reset

Ports:
- clock  in  1  system clock; all state updates on posedge
- reset  in  1  synchronous, active-high reset
- stall  in  1  hold PC, state and outputs this cycle
- branch_taken  in  1  redirect request from execute stage
- branch_target  in  ADDR_W  redirect address
- imem_addr  out  ADDR_W  instruction-memory read address; combinational, equals pc
- imem_data  in  9  instruction word; combinational read of imem_addr
- out_format  out  1  instruction format bit (1 = immediate follows)
- out_opcode  out  4  opcode
- out_sign  out  1  sign bit
- out_operand  out  3  register operand
- out_immediate  out  8  immediate (0 when format = 0)
- out_valid  out  1  field bundle valid this cycle
- out_pc  out  ADDR_W  address of first word of emitted instruction
- flush  out  1  one-cycle pulse to the IF/ID register flush input

Behaviour:
- Word layout: [8] format, [7:4] opcode, [3] sign, [2:0] operand. For format = 1, the next word's [7:0] is the immediate and its [8] is ignored.
- Reset, synchronous, active-high: pc = RESET_PC, state = S_FETCH, all out_* = 0, out_valid = 0, flush = 0. Reset mid-S_IMM discards the partial instruction.
- States:
  - S_FETCH, format = 0: register fields, out_immediate = 0, out_pc = pc, out_valid = 1, pc += 1.
  - S_FETCH, format = 1: latch fields and start address internally, pc += 1, go S_IMM, out_valid = 0.
  - S_IMM: out_immediate = imem_data[7:0], emit latched fields with out_pc = latched start address, out_valid = 1, pc += 1, go S_FETCH.
- Latency: outputs are registered and valid on the cycle after the final word of the instruction is read.
- Priority, highest first: reset > branch_taken > stall > normal.
- branch_taken:
  - pc = branch_target; state = S_FETCH; discard any partial instruction.
  - out_valid = 0 next cycle; flush = 1 for exactly one cycle, then 0 on the following cycle unless another branch arrives.
  - Back-to-back branches keep flush high each cycle.
- stall without branch: pc, state, latched fields and all out_* hold, including out_valid. flush = 0.
- PC arithmetic is modulo 2^ADDR_W.
  - Wrap from all-ones to 0 is legal.
  - An immediate word at the wrapped address is valid.

Optional Feature:
- Macro: IFETCH_HALT_EN.
- Defined:
  - A format-0 word with opcode 4'hF is emitted once, then the FSM enters S_HALT.
  - S_HALT: pc frozen, out_valid = 0, imem_addr steady.
  - Only reset or branch_taken leaves S_HALT.
- Not defined: opcode 4'hF is an ordinary instruction and no S_HALT state exists.

Decomposition:
- Shared package holds:
  - field bit positions and widths (FMT_BIT, OPC_MSB/LSB, SIGN_BIT, OPR_MSB/LSB, IMM_W)
  - state encodings S_FETCH, S_IMM, S_HALT
  - OPC_HALT = 4'hF
- One natural sub-module, ifetch_pc: a register with load, increment and hold controls, parameterised by ADDR_W and RESET_PC.

Test Plan:
- Reset, then memory {0x023, 0x1A5, 0x07F, 0x012}
  - -> cycle 1: valid, opcode 2, sign 0, operand 3, imm 0, pc 0
  - -> cycle 2: valid 0
  - -> cycle 3: valid, format 1, opcode A, sign 0, operand 5, imm 0x7F, pc 1
- stall held for 3 cycles mid S_IMM -> outputs and imem_addr frozen; correct imm emitted after release.
- branch_taken, target 0x040, during S_IMM -> flush = 1 for exactly 1 cycle, valid 0, next fetch at 0x040, partial instruction dropped.
- branch_taken and stall both high -> redirect wins; flush asserted; pc = target.
- pc = 0x3FF holding a format-1 word, immediate at 0x000 = 0x0AB -> imm 0xAB, out_pc 0x3FF, next pc 0x001.
- With IFETCH_HALT_EN: word 0x0F0 -> emitted once, then valid stays 0 and pc frozen until branch_taken. Without the macro, fetch continues.
